// File: rtl/puf_pkg.sv
// Shared types, sizes and the channel-walk helper for the PUF mux scan sequencer.
// Latency: none (types and a combinational function). Backpressure: not applicable.
package puf_pkg;

   localparam int SEL_W  = 4;
   localparam int N_CH   = 2**SEL_W;
   localparam int VOTE_N = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } scan_state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } next_idx_t;

   // Lowest enabled channel strictly above cur. Descending walk so the lowest hit wins.
   function automatic next_idx_t next_en_idx(input logic [N_CH-1:0] mask,
                                             input logic [SEL_W-1:0] cur);
      next_idx_t r;
      r = '0;
      for (int i = N_CH-1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            r.found = 1'b1;
            r.idx   = SEL_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/puf_mux_scan_ctrl_if.sv
// Scan request / response handshake plus the mux select and mux sample lines.
// Latency: wires only. Backpressure: resp_valid is held until resp_ack.
interface puf_mux_scan_ctrl_if;
   import puf_pkg::*;

   logic             start;
   logic [N_CH-1:0]  ch_mask;
   logic             mux_out;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             resp_valid;
   logic [N_CH-1:0]  resp;
   logic             resp_ack;

   modport master (
      output start, ch_mask, mux_out, resp_ack,
      input  sel, busy, resp_valid, resp
   );

   modport slave (
      input  start, ch_mask, mux_out, resp_ack,
      output sel, busy, resp_valid, resp
   );

endinterface

// File: rtl/puf_settle_timer.sv
// Loadable 8-bit down-counter; expire is high while the count sits at zero.
// Latency: load visible next cycle. Backpressure: none; dec is ignored at zero.
module puf_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       expire
);

   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != 8'd0)) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   assign expire = (cnt_q == 8'd0);

endmodule

// File: rtl/puf_mux_scan_ctrl.sv
// Walks sel over enabled channels, settles, samples mux_out into a 16-bit response word.
// Latency: k*(SETTLE_CYC+1) cycles for k enabled channels (x3 with PUF_VOTE_EN majority voting).
// Backpressure: response held with resp_valid until resp_ack; start is ignored while busy.
module puf_mux_scan_ctrl
   import puf_pkg::*;
#(
   parameter int SETTLE_CYC = 4
) (
   input logic                clk,
   input logic                rst_n,
   puf_mux_scan_ctrl_if.slave bus
);

   scan_state_t      state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_CH-1:0]  mask_q, mask_d;
   logic [N_CH-1:0]  resp_q, resp_d;
   logic             tmr_load, tmr_dec, tmr_exp;
   next_idx_t        first, nxt;

`ifdef PUF_VOTE_EN
   logic [1:0]       vcnt_q, vcnt_d;
   logic [1:0]       ones_q, ones_d;
   logic [1:0]       vote_sum;
`endif

   puf_settle_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (8'(SETTLE_CYC - 1)),
      .dec      (tmr_dec),
      .expire   (tmr_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         mask_q  <= '0;
         resp_q  <= '0;
`ifdef PUF_VOTE_EN
         vcnt_q  <= '0;
         ones_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mask_q  <= mask_d;
         resp_q  <= resp_d;
`ifdef PUF_VOTE_EN
         vcnt_q  <= vcnt_d;
         ones_q  <= ones_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      mask_d   = mask_q;
      resp_d   = resp_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
`ifdef PUF_VOTE_EN
      vcnt_d   = vcnt_q;
      ones_d   = ones_q;
      vote_sum = ones_q + {1'b0, bus.mux_out};
`endif

      // Channel 0 has nothing below it, so it is tested directly rather than through the helper.
      first = next_en_idx(bus.ch_mask, '0);
      if (bus.ch_mask[0]) begin
         first.found = 1'b1;
         first.idx   = '0;
      end
      nxt = next_en_idx(mask_q, sel_q);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mask_d = bus.ch_mask;
               resp_d = '0;
               if (first.found) begin
                  sel_d    = first.idx;
                  tmr_load = 1'b1;
                  state_d  = SETTLE;
               end else begin
                  state_d  = DONE;
               end
            end
         end

         SETTLE: begin
            if (tmr_exp) begin
               state_d = SAMPLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         SAMPLE: begin
`ifdef PUF_VOTE_EN
            if (vcnt_q != 2'(VOTE_N - 1)) begin
               // Re-settle on the same channel before the next vote sample.
               vcnt_d   = vcnt_q + 2'd1;
               ones_d   = vote_sum;
               tmr_load = 1'b1;
               state_d  = SETTLE;
            end else begin
               resp_d[sel_q] = (vote_sum >= 2'd2);
               vcnt_d        = '0;
               ones_d        = '0;
               if (nxt.found) begin
                  sel_d    = nxt.idx;
                  tmr_load = 1'b1;
                  state_d  = SETTLE;
               end else begin
                  state_d  = DONE;
               end
            end
`else
            resp_d[sel_q] = bus.mux_out;
            if (nxt.found) begin
               sel_d    = nxt.idx;
               tmr_load = 1'b1;
               state_d  = SETTLE;
            end else begin
               state_d  = DONE;
            end
`endif
         end

         DONE: begin
            if (bus.resp_ack) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.sel        = sel_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.resp_valid = (state_q == DONE);
   assign bus.resp       = resp_q;

endmodule

// File: tb/tb_puf_mux_scan_ctrl.sv
// Directed bench for puf_mux_scan_ctrl: full, sparse and empty scans, handshake hold,
// simultaneous ack/start, and asynchronous reset in the middle of a scan.
module tb_puf_mux_scan_ctrl;
   import puf_pkg::*;

   localparam int S = 4;
`ifdef PUF_VOTE_EN
   localparam int LAT = VOTE_N * (S + 1);
`else
   localparam int LAT = S + 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_pat;
   logic        flip;
   int          n_chk = 0;
   int          n_bad = 0;

   puf_mux_scan_ctrl_if bus();

   puf_mux_scan_ctrl #(.SETTLE_CYC(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mux_out = in_pat[bus.sel] ^ flip;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic ack();
      bus.resp_ack = 1'b1;
      tick();
      bus.resp_ack = 1'b0;
   endtask

   // Accept a scan, then follow sel cycle by cycle against the ascending list of enabled channels.
   task automatic run_scan(input string tag, input logic [15:0] m, input logic [15:0] pat);
      int en_idx[$];
      int sel_err;
      int vld_err;
      int ch;
      en_idx  = {};
      sel_err = 0;
      vld_err = 0;
      for (int i = 0; i < 16; i++) if (m[i]) en_idx.push_back(i);
      in_pat      = pat;
      bus.ch_mask = m;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      for (int j = 0; j < en_idx.size() * LAT; j++) begin
         ch = en_idx[j / LAT];
`ifdef PUF_VOTE_EN
         flip = (ch == 3) && ((j % LAT) >= S + 1) && ((j % LAT) < 2 * (S + 1));
`endif
         if (int'(bus.sel) != ch) sel_err++;
         if (bus.resp_valid !== 1'b0) vld_err++;
         tick();
      end
      flip = 1'b0;
      chk({tag, "_sel_seq"}, sel_err, 0);
      chk({tag, "_early_vld"}, vld_err, 0);
      chk({tag, "_vld"}, bus.resp_valid, 1);
      chk({tag, "_resp"}, bus.resp, pat & m);
      chk({tag, "_busy"}, bus.busy, 1);
   endtask

   initial begin
      int hold_err;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.ch_mask  = '0;
      bus.resp_ack = 1'b0;
      in_pat       = '0;
      flip         = 1'b0;

      #12;
      chk("rst_sel", bus.sel, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_vld", bus.resp_valid, 0);
      chk("rst_resp", bus.resp, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Full mask: 16 channels, 80 cycles in the single-sample build.
      run_scan("full", 16'hFFFF, 16'hA5C3);

      // Hold in DONE with ack low; a start pulse here must be dropped.
      hold_err = 0;
      for (int i = 0; i < 20; i++) begin
         bus.start   = (i == 5);
         bus.ch_mask = 16'h00FF;
         tick();
         bus.start = 1'b0;
         if (bus.resp_valid !== 1'b1 || bus.resp !== 16'hA5C3 || bus.busy !== 1'b1) hold_err++;
      end
      chk("hold_stable", hold_err, 0);
      ack();
      chk("ack_vld", bus.resp_valid, 0);
      chk("ack_busy", bus.busy, 0);
      chk("ack_resp_kept", bus.resp, 16'hA5C3);
      tick();
      chk("start_not_queued", bus.busy, 0);

      // Sparse mask: only channels 0 and 15, no time spent on the ones between.
      run_scan("sparse", 16'h8001, 16'hFFFF);

      // Ack and start together in DONE: ack wins, start is lost.
      bus.resp_ack = 1'b1;
      bus.start    = 1'b1;
      bus.ch_mask  = 16'hFFFF;
      tick();
      bus.resp_ack = 1'b0;
      bus.start    = 1'b0;
      chk("ackstart_busy", bus.busy, 0);
      chk("ackstart_vld", bus.resp_valid, 0);
      tick();
      chk("ackstart_dropped", bus.busy, 0);

      // Empty mask: response valid right after the accept edge, resp cleared to zero.
      run_scan("empty", 16'h0000, 16'hFFFF);
      ack();
      chk("empty_idle_busy", bus.busy, 0);

      // Asynchronous reset in cycle 10 of a full scan: channels 0 and 1 already sampled.
      in_pat      = 16'hA5C3;
      bus.ch_mask = 16'hFFFF;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      repeat (10) tick();
`ifdef PUF_VOTE_EN
      chk("mid_sel", bus.sel, 0);
`else
      chk("mid_sel", bus.sel, 2);
      chk("mid_resp", bus.resp, 16'h0003);
`endif
      rst_n = 1'b0;
      #1;
      chk("midrst_sel", bus.sel, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_vld", bus.resp_valid, 0);
      chk("midrst_resp", bus.resp, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("postrst_idle", bus.busy, 0);
      run_scan("rescan", 16'hFFFF, 16'h1234);
      ack();
      chk("rescan_idle", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
